// File: rtl/hue_wheel_engine_if.sv
// Multiplier handshake bundle between hue_wheel_engine (master) and the
// shared external multiplier (slave).
interface hue_wheel_engine_if #(
  parameter int DW = 8
);
  logic [DW-1:0]   mult_a;
  logic [DW-1:0]   mult_b;
  logic            mult_ld;
  logic            mult_ok;
  logic [2*DW-1:0] mult_res;

  modport master (
    output mult_a,
    output mult_b,
    output mult_ld,
    input  mult_ok,
    input  mult_res
  );

  modport slave (
    input  mult_a,
    input  mult_b,
    input  mult_ld,
    output mult_ok,
    output mult_res
  );
endinterface

// File: rtl/hue_wheel_engine.sv
// hue_wheel_engine: RGBW colour generator. Direct mode passes raw RGBW
// through; wheel mode converts a hue index to RGB by sector arithmetic,
// adds a saturating white tint and scales all four channels by an
// intensity factor using the shared external multiplier.
// Optional build macro HUE_WHEEL_GAMMA_EN adds a square-law intensity
// pre-multiply (extra MUL_L state ahead of the channel multiplies).
module hue_wheel_engine #(
  parameter int         DW          = 8,
  parameter int         SEG_LEN     = 43,
  parameter int         RAMP_STEP   = 6,
  parameter logic [7:0] MODE_DIRECT = 8'h21,
  parameter logic [7:0] MODE_WHEEL  = 8'hA4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           mode,
  input  logic [DW-1:0]        lint,
  input  logic [DW-1:0]        color_idx,
  input  logic [DW-1:0]        white_in,
  input  logic [DW-1:0]        red_in,
  input  logic [DW-1:0]        green_in,
  input  logic [DW-1:0]        blue_in,
  hue_wheel_engine_if.master   mul,
  output logic [DW-1:0]        red_out,
  output logic [DW-1:0]        green_out,
  output logic [DW-1:0]        blue_out,
  output logic [DW-1:0]        white_out,
  output logic                 out_valid,
  output logic                 busy
);

  localparam logic [DW-1:0]   M       = '1;
  localparam logic [DW-1:0]   SEG     = DW'(SEG_LEN);
  localparam logic [2*DW-1:0] STEP_W  = (2*DW)'(RAMP_STEP);

  typedef enum logic [3:0] {
    IDLE,
    DIV,
    HUE,
    TINT,
`ifdef HUE_WHEEL_GAMMA_EN
    MUL_L,
`endif
    MUL_W,
    MUL_R,
    MUL_G,
    MUL_B,
    OUT
  } state_t;

  state_t        state_q;
  logic [DW-1:0] rem_q;
  logic [2:0]    sector_q;
`ifdef HUE_WHEEL_GAMMA_EN
  logic [DW-1:0] lint_q;
`endif
  logic [DW-1:0] lint_eff_q;
  logic [DW-1:0] white_q;
  logic [DW-1:0] r_q, g_q, b_q, w_q;
  logic [DW-1:0] mult_a_q, mult_b_q;
  logic          mult_ld_q;
  logic [DW-1:0] red_out_q, green_out_q, blue_out_q, white_out_q;
  logic          out_valid_q;

  logic [2*DW-1:0] ramp_wide_d;
  logic [DW-1:0]   ramp_d;
  logic [DW-1:0]   hue_r_d, hue_g_d, hue_b_d;
  logic [DW:0]     sum_r_d, sum_g_d, sum_b_d;
  logic [DW-1:0]   tint_r_d, tint_g_d, tint_b_d;
  logic [DW-1:0]   mul_b_d;
  state_t          mul_next_d;
  logic [DW-1:0]   prod_hi;
  logic            unused_prod_lo;

  assign prod_hi        = mul.mult_res[2*DW-1:DW];
  assign unused_prod_lo = ^mul.mult_res[DW-1:0];

  // Hue ramp, sector colour and saturating white tint from the current buffers
  always_comb begin
    ramp_wide_d = {{DW{1'b0}}, rem_q} * STEP_W;
    ramp_d      = (ramp_wide_d > {{DW{1'b0}}, M}) ? M : ramp_wide_d[DW-1:0];
    hue_r_d     = M;
    hue_g_d     = '0;
    hue_b_d     = ramp_d;
    case (sector_q)
      3'd0: begin hue_r_d = M;          hue_g_d = '0;         hue_b_d = ramp_d;     end
      3'd1: begin hue_r_d = M - ramp_d; hue_g_d = '0;         hue_b_d = M;          end
      3'd2: begin hue_r_d = '0;         hue_g_d = ramp_d;     hue_b_d = M;          end
      3'd3: begin hue_r_d = '0;         hue_g_d = M;          hue_b_d = M - ramp_d; end
      3'd4: begin hue_r_d = ramp_d;     hue_g_d = M;          hue_b_d = '0;         end
      default: begin hue_r_d = M;       hue_g_d = M - ramp_d; hue_b_d = '0;         end
    endcase
    sum_r_d  = {1'b0, r_q} + {1'b0, white_q};
    sum_g_d  = {1'b0, g_q} + {1'b0, white_q};
    sum_b_d  = {1'b0, b_q} + {1'b0, white_q};
    tint_r_d = sum_r_d[DW] ? M : sum_r_d[DW-1:0];
    tint_g_d = sum_g_d[DW] ? M : sum_g_d[DW-1:0];
    tint_b_d = sum_b_d[DW] ? M : sum_b_d[DW-1:0];
  end

  // Operand B and follow-on state for whichever multiply state is active
  always_comb begin
    mul_b_d    = white_q;
    mul_next_d = MUL_R;
    case (state_q)
`ifdef HUE_WHEEL_GAMMA_EN
      MUL_L: begin mul_b_d = lint_q;  mul_next_d = MUL_W; end
`endif
      MUL_W: begin mul_b_d = white_q; mul_next_d = MUL_R; end
      MUL_R: begin mul_b_d = r_q;     mul_next_d = MUL_G; end
      MUL_G: begin mul_b_d = g_q;     mul_next_d = MUL_B; end
      MUL_B: begin mul_b_d = b_q;     mul_next_d = OUT;   end
      default: ;
    endcase
  end

  // Control FSM with registered datapath, multiplier handshake and outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      sector_q    <= '0;
`ifdef HUE_WHEEL_GAMMA_EN
      lint_q      <= '0;
`endif
      lint_eff_q  <= '0;
      white_q     <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      w_q         <= '0;
      mult_a_q    <= '0;
      mult_b_q    <= '0;
      mult_ld_q   <= 1'b0;
      red_out_q   <= '0;
      green_out_q <= '0;
      blue_out_q  <= '0;
      white_out_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mode == MODE_DIRECT) begin
            red_out_q   <= red_in;
            green_out_q <= green_in;
            blue_out_q  <= blue_in;
            white_out_q <= white_in;
            out_valid_q <= 1'b1;
          end else if (mode == MODE_WHEEL) begin
            rem_q      <= color_idx;
            sector_q   <= '0;
`ifdef HUE_WHEEL_GAMMA_EN
            lint_q     <= lint;
`endif
            lint_eff_q <= lint;
            white_q    <= white_in;
            state_q    <= DIV;
          end
        end
        DIV: begin
          // One subtraction per cycle; the last sector absorbs any residue
          if (rem_q >= SEG && sector_q < 3'd5) begin
            rem_q    <= rem_q - SEG;
            sector_q <= sector_q + 3'd1;
          end else begin
            state_q <= HUE;
          end
        end
        HUE: begin
          r_q     <= hue_r_d;
          g_q     <= hue_g_d;
          b_q     <= hue_b_d;
          state_q <= TINT;
        end
        TINT: begin
          r_q <= tint_r_d;
          g_q <= tint_g_d;
          b_q <= tint_b_d;
`ifdef HUE_WHEEL_GAMMA_EN
          state_q <= MUL_L;
`else
          state_q <= MUL_W;
`endif
        end
`ifdef HUE_WHEEL_GAMMA_EN
        MUL_L,
`endif
        MUL_W, MUL_R, MUL_G, MUL_B: begin
          // Request only from a fully idle handshake; that also guarantees
          // a low cycle on mult_ld between consecutive operations.
          if (!mult_ld_q && !mul.mult_ok) begin
            mult_ld_q <= 1'b1;
            mult_a_q  <= lint_eff_q;
            mult_b_q  <= mul_b_d;
          end else if (mult_ld_q && mul.mult_ok) begin
            mult_ld_q <= 1'b0;
            case (state_q)
`ifdef HUE_WHEEL_GAMMA_EN
              MUL_L:   lint_eff_q <= prod_hi;
`endif
              MUL_W:   w_q <= prod_hi;
              MUL_R:   r_q <= prod_hi;
              MUL_G:   g_q <= prod_hi;
              default: b_q <= prod_hi;
            endcase
            state_q <= mul_next_d;
          end
        end
        OUT: begin
          red_out_q   <= r_q;
          green_out_q <= g_q;
          blue_out_q  <= b_q;
          white_out_q <= w_q;
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul.mult_a  = mult_a_q;
  assign mul.mult_b  = mult_b_q;
  assign mul.mult_ld = mult_ld_q;
  assign red_out     = red_out_q;
  assign green_out   = green_out_q;
  assign blue_out    = blue_out_q;
  assign white_out   = white_out_q;
  assign out_valid   = out_valid_q;
  assign busy        = (state_q != IDLE);

endmodule
